// File: rtl/lsu_mem_initiator_if.sv
// Pipeline request/response and data-memory bus of the RV32I load/store initiator.
// master: the initiator itself; slave: the pipeline plus memory that surround it.
interface lsu_mem_initiator_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// RV32I load/store initiator: word-aligned memory transactions with byte enables.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses in two; otherwise they are rejected.
module lsu_mem_initiator #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  lsu_mem_initiator_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic [1:0] ACC1 = 2'd2;
`endif
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;

  logic [1:0]        off;
  logic [3:0]        size_mask;
  logic              legal;
  logic              misaligned;
  logic              reject;
  logic [3:0]        be_lo;
  logic [DATA_W-1:0] wdata_lo;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] rsp_data_next;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q;
  logic [3:0]        be_hi_q;
  logic [DATA_W-1:0] wdata_hi_q;
  logic [DATA_W-1:0] rdata_lo_q;
  logic [1:0]        off_neg;
  logic [1:0]        off_neg_q;
  logic [3:0]        be_hi;
  logic [DATA_W-1:0] wdata_hi;
`endif

  function automatic logic [DATA_W-1:0] extend(input logic [2:0] f3, input logic [DATA_W-1:0] d);
    case (f3)
      3'b000:  extend = {{(DATA_W-8){d[7]}}, d[7:0]};
      3'b001:  extend = {{(DATA_W-16){d[15]}}, d[15:0]};
      3'b100:  extend = {{(DATA_W-8){1'b0}}, d[7:0]};
      3'b101:  extend = {{(DATA_W-16){1'b0}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign bus.req_ready = (state_q == IDLE);

  // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    off       = bus.req_addr[1:0];
    word_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
    case (bus.req_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.req_we;
      default:                legal = 1'b0;
    endcase
    misaligned = (bus.req_funct3[1:0] == 2'b01 && off == 2'b11) ||
                 (bus.req_funct3[1:0] == 2'b10 && off != 2'b00);
    be_lo      = size_mask << off;
    wdata_lo   = bus.req_wdata << {off, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
    reject     = !legal;
    // The second word holds the bytes that spilled past lane 3.
    off_neg    = 2'd0 - off;
    off_neg_q  = 2'd0 - off_q;
    be_hi      = size_mask >> off_neg;
    wdata_hi   = bus.req_wdata >> {off_neg, 3'b000};
    load_word  = (state_q == ACC1) ? (rdata_lo_q | (bus.mem_rdata << {off_neg_q, 3'b000}))
                                   : (bus.mem_rdata >> {off_q, 3'b000});
`else
    reject     = !legal || misaligned;
    load_word  = bus.mem_rdata >> {off_q, 3'b000};
`endif
    rsp_data_next = bus.mem_we ? '0 : extend(funct3_q, load_word);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      funct3_q      <= '0;
      off_q         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q       <= 1'b0;
      be_hi_q       <= '0;
      wdata_hi_q    <= '0;
      rdata_lo_q    <= '0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state_q)
        IDLE: if (bus.req_valid) begin
          funct3_q <= bus.req_funct3;
          off_q    <= off;
          if (reject) begin
            state_q       <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
          end else begin
            state_q       <= ACC0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.req_we;
            bus.mem_be    <= be_lo;
            bus.mem_addr  <= word_addr;
            bus.mem_wdata <= wdata_lo;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q       <= misaligned;
            be_hi_q       <= be_hi;
            wdata_hi_q    <= wdata_hi;
`endif
          end
        end
        ACC0: if (bus.mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) begin
            // mem_req stays high: the second word is a fresh transaction.
            state_q       <= ACC1;
            bus.mem_addr  <= bus.mem_addr + ADDR_W'(4);
            bus.mem_be    <= be_hi_q;
            bus.mem_wdata <= wdata_hi_q;
            rdata_lo_q    <= load_word;
          end else
`endif
          begin
            state_q       <= RESP;
            bus.mem_req   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= rsp_data_next;
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ACC1: if (bus.mem_ack) begin
          state_q       <= RESP;
          bus.mem_req   <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= rsp_data_next;
        end
`endif
        RESP: begin
          state_q       <= IDLE;
          bus.rsp_rdata <= '0;
          bus.rsp_err   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed cases plus random loads/stores
// checked against a byte-level memory model.
module tb_lsu_mem_initiator;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_mem_initiator_if #(.ADDR_W(32)) bus ();

  lsu_mem_initiator #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  mem_model [logic [31:0]];

  logic [31:0] obs_addr [2];
  logic [3:0]  obs_be   [2];
  logic [31:0] obs_wd   [2];
  logic        obs_we   [2];
  logic [31:0] obs_rd;
  logic        obs_err;
  int          obs_lat;
  int          obs_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 8'h00;
  endfunction

  task automatic write_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem_model[a + 32'(k)] = w[8*k +: 8];
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int s;
    logic [31:0] v;
    s = size_of(f3);
    v = '0;
    for (int k = 0; k < s; k++) v = v | (32'(rd_byte(addr + 32'(k))) << (8*k));
    if (!f3[2] && s < 4 && v[8*s-1]) v = v | (32'hFFFF_FFFF << (8*s));
    return v;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int d0, input int d1, input string tag);
    int s, n_exp, exp_lat, acc_i, wcnt, cyc, dly;
    bit legal, mis, err, done, stable_ok, ready_ok;
    logic [31:0] w0, a, exp_rd, cap_addr, cap_wd;
    logic [31:0] exp_addr [2];
    logic [3:0]  exp_be   [2];
    logic [31:0] exp_wd   [2];
    logic [3:0]  cap_be;
    logic        cap_we;
    int idx, lane;

    s     = size_of(f3);
    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
            (((f3 == 3'b100) || (f3 == 3'b101)) && !we);
    mis   = (32'(addr[1:0]) + 32'(s)) > 4;
    err   = !legal || (mis && !SPLIT);
    n_exp = err ? 0 : (mis ? 2 : 1);
    w0    = addr & ~32'h3;
    exp_addr[0] = w0;
    exp_addr[1] = w0 + 32'd4;
    for (int i = 0; i < 2; i++) begin
      exp_be[i] = '0;
      exp_wd[i] = '0;
      obs_addr[i] = '0; obs_be[i] = '0; obs_wd[i] = '0; obs_we[i] = 1'b0;
    end
    for (int k = 0; k < s; k++) begin
      a    = addr + 32'(k);
      idx  = ((a & ~32'h3) == w0) ? 0 : 1;
      lane = int'(a[1:0]);
      exp_be[idx][lane] = 1'b1;
      exp_wd[idx][8*lane +: 8] = wdata[8*k +: 8];
    end
    exp_rd  = (err || we) ? 32'h0 : model_load(f3, addr);
    exp_lat = err ? 1 : 1 + (d0 + 1) + ((n_exp == 2) ? d1 + 1 : 0);

    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(bus.req_ready), 32'h1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;

    done = 0; cyc = 0; acc_i = 0; wcnt = 0; obs_n = 0; stable_ok = 1; ready_ok = 1; obs_lat = -1;
    obs_rd = '0; obs_err = 1'b0;
    cap_addr = '0; cap_wd = '0; cap_be = '0; cap_we = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.req_valid = 1'b0;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        acc_i++;
        wcnt = 0;
      end
      bus.mem_rdata = $urandom;
      if (bus.rsp_valid) begin
        obs_lat = cyc;
        obs_rd  = bus.rsp_rdata;
        obs_err = bus.rsp_err;
        done    = 1;
      end else begin
        if (bus.req_ready) ready_ok = 0;
        if (bus.mem_req) begin
          if (wcnt == 0) begin
            obs_n++;
            cap_addr = bus.mem_addr; cap_be = bus.mem_be; cap_wd = bus.mem_wdata; cap_we = bus.mem_we;
            if (acc_i < 2) begin
              obs_addr[acc_i] = cap_addr; obs_be[acc_i] = cap_be;
              obs_wd[acc_i] = cap_wd; obs_we[acc_i] = cap_we;
            end
          end else if (bus.mem_addr !== cap_addr || bus.mem_be !== cap_be ||
                       bus.mem_wdata !== cap_wd || bus.mem_we !== cap_we) begin
            stable_ok = 0;
          end
          dly = (acc_i == 0) ? d0 : d1;
          if (wcnt >= dly) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = {rd_byte(bus.mem_addr + 32'd3), rd_byte(bus.mem_addr + 32'd2),
                             rd_byte(bus.mem_addr + 32'd1), rd_byte(bus.mem_addr)};
          end else begin
            wcnt++;
          end
        end
      end
    end

    check({tag, "_latency"}, 32'(obs_lat), 32'(exp_lat));
    check({tag, "_rsp_err"}, 32'(obs_err), 32'(err));
    check({tag, "_rsp_rdata"}, obs_rd, exp_rd);
    check({tag, "_num_access"}, 32'(obs_n), 32'(n_exp));
    check({tag, "_stable"}, 32'(stable_ok), 32'h1);
    check({tag, "_ready_low"}, 32'(ready_ok), 32'h1);
    for (int i = 0; i < n_exp; i++) begin
      check({tag, "_mem_addr"}, obs_addr[i], exp_addr[i]);
      check({tag, "_mem_be"}, 32'(obs_be[i]), 32'(exp_be[i]));
      check({tag, "_mem_we"}, 32'(obs_we[i]), 32'(we));
      check({tag, "_mem_wdata"}, obs_wd[i] & lane_mask(exp_be[i]), exp_wd[i]);
    end

    @(negedge clk);
    check({tag, "_rsp_pulse"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'h1);
    bus.mem_ack = 1'b0;

    if (!err && we)
      for (int k = 0; k < s; k++) mem_model[addr + 32'(k)] = wdata[8*k +: 8];
  endtask

  logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] ill_f3   [3] = '{3'b011, 3'b110, 3'b111};

  initial begin
    bit saw_rsp;
    logic [2:0]  f3;
    logic [31:0] a;
    logic        we;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'h1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_mem_be", 32'(bus.mem_be), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    rst_n = 1'b1;

    for (int k = 0; k < 64; k += 4) write_word(32'h100 + 32'(k), $urandom);
    write_word(32'hFFFF_FFF8, $urandom);
    write_word(32'hFFFF_FFFC, $urandom);
    write_word(32'h0, $urandom);

    write_word(32'h100, 32'h8000_0000);
    do_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, "t1_lb");
    check("t1_addr", obs_addr[0], 32'h100);
    check("t1_be", 32'(obs_be[0]), 32'h8);
    check("t1_rdata", obs_rd, 32'hFFFF_FF80);
    check("t1_lat", 32'(obs_lat), 32'd2);

    do_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, "t2_lbu");
    check("t2_lbu_rdata", obs_rd, 32'h0000_0080);
    write_word(32'h100, 32'h8001_0000);
    do_op(1'b0, 3'b101, 32'h102, 32'h0, 1, 0, "t2_lhu");
    check("t2_lhu_rdata", obs_rd, 32'h0000_8001);

    do_op(1'b1, 3'b001, 32'h102, 32'h0000_1234, 0, 0, "t3_sh");
    check("t3_we", 32'(obs_we[0]), 32'h1);
    check("t3_be", 32'(obs_be[0]), 32'hC);
    check("t3_wdata", obs_wd[0], 32'h1234_0000);
    check("t3_err", 32'(obs_err), 32'h0);

    write_word(32'h100, 32'hDDCC_BBAA);
    write_word(32'h104, 32'h1122_3344);
    do_op(1'b0, 3'b010, 32'h101, 32'h0, 1, 2, "t4_lw_mis");
`ifdef LSU_MISALIGN_SPLIT_EN
    check("t4_be0", 32'(obs_be[0]), 32'hE);
    check("t4_be1", 32'(obs_be[1]), 32'h1);
    check("t4_rdata", obs_rd, 32'h44DD_CCBB);
    check("t4_err", 32'(obs_err), 32'h0);
`else
    check("t4_err", 32'(obs_err), 32'h1);
    check("t4_no_req", 32'(obs_n), 32'h0);
`endif

    write_word(32'h200, 32'hCAFE_F00D);
    do_op(1'b0, 3'b010, 32'h200, 32'h0, 3, 0, "t5_wait");
    check("t5_lat", 32'(obs_lat), 32'd5);
    check("t5_rdata", obs_rd, 32'hCAFE_F00D);

    for (int i = 0; i < 3; i++) begin
      do_op(1'($urandom_range(0, 1)), ill_f3[i], 32'h104, $urandom, 0, 0, "ill_funct3");
      check("ill_err", 32'(obs_err), 32'h1);
    end
    do_op(1'b1, 3'b100, 32'h104, $urandom, 0, 0, "ill_store_bu");
    check("ill_store_err", 32'(obs_err), 32'h1);

    do_op(1'b1, 3'b010, 32'hFFFF_FFFD, 32'hA1B2_C3D4, 0, 1, "wrap_sw");
    do_op(1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0, 2, 0, "wrap_lw");
    do_op(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 0, 0, "wrap_lh");

    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("stray_ack_ready", 32'(bus.req_ready), 32'h1);
    check("stray_ack_req", 32'(bus.mem_req), 32'h0);
    check("stray_ack_rsp", 32'(bus.rsp_valid), 32'h0);

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h200;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_mid_req_before", 32'(bus.mem_req), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_drop", 32'(bus.mem_req), 32'h0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_rsp = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.mem_req) saw_rsp = 1;
    end
    check("rst_mid_quiet", 32'(saw_rsp), 32'h0);
    do_op(1'b0, 3'b010, 32'h200, 32'h0, 0, 0, "rst_after");

    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                       : 32'h100 + 32'($urandom_range(0, 15));
      do_op(we, f3, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
